// File: rtl/fifo_pkg.sv
// fifo_pkg: shared pointer-width helper, pointer type and default depth for the FIFO family
package fifo_pkg;
    function automatic int ptr_w(input int addrsize);
        return addrsize + 1;
    endfunction
    localparam int ADDRSIZE_DEF = 4;
    localparam int DEPTH = 1 << ADDRSIZE_DEF;
    typedef logic [ptr_w(ADDRSIZE_DEF)-1:0] ptr_t;
endpackage

// File: rtl/fifo_ram_sync.sv
// fifo_ram_sync: two-port storage array, one write port and one registered read port
module fifo_ram_sync #(
    parameter int DATASIZE = 8,
    parameter int ADDRSIZE = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                we,
    input  logic [ADDRSIZE-1:0] waddr,
    input  logic [DATASIZE-1:0] wdata,
    input  logic                re,
    input  logic [ADDRSIZE-1:0] raddr,
    output logic [DATASIZE-1:0] rdata
);
    logic [DATASIZE-1:0] mem [1<<ADDRSIZE];
    always_ff @(posedge clk)
        if (we) mem[waddr] <= wdata;
    // only the output register is reset; the array keeps stale contents
    always_ff @(posedge clk)
        if (rst) rdata <= '0;
        else if (re) rdata <= mem[raddr];
endmodule

// File: rtl/sync_fifo_ctrl_mem.sv
// sync_fifo_ctrl_mem: single-clock FIFO with registered read, occupancy, almost flags and sticky errors
module sync_fifo_ctrl_mem
    import fifo_pkg::*;
#(
    parameter int DATASIZE      = 8,
    parameter int ADDRSIZE      = 4,
    parameter int AFULL_THRESH  = (1 << ADDRSIZE) - 2,
    parameter int AEMPTY_THRESH = 2
) (
    input  logic                wclk,
    input  logic                wrst,
    input  logic                winc,
    input  logic [DATASIZE-1:0] wdata,
    input  logic                rinc,
    output logic [DATASIZE-1:0] rdata,
    output logic                rvalid,
    output logic                wfull,
    output logic                walmost_full,
    output logic                rempty,
    output logic                ralmost_empty,
    output logic [ADDRSIZE:0]   count,
    output logic                overflow,
    output logic                underflow
);
    localparam int PW = ptr_w(ADDRSIZE);
    logic [PW-1:0] wptr, rptr;
    logic we, re;
    // all flags derive from registered pointers, so winc/rinc never reach an output combinationally
    assign rempty        = wptr == rptr;
    assign wfull         = (wptr[PW-1] != rptr[PW-1]) && (wptr[PW-2:0] == rptr[PW-2:0]);
    assign count         = wptr - rptr;
    assign walmost_full  = int'(count) >= AFULL_THRESH;
    assign ralmost_empty = int'(count) <= AEMPTY_THRESH;
    assign we            = winc && !wfull;
    assign re            = rinc && !rempty;
    always_ff @(posedge wclk)
        if (wrst) begin
            wptr      <= '0;
            rptr      <= '0;
            rvalid    <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (we) wptr <= wptr + PW'(1);
            if (re) rptr <= rptr + PW'(1);
            rvalid    <= re;
            overflow  <= overflow | (winc & wfull);
            underflow <= underflow | (rinc & rempty);
        end
    fifo_ram_sync #(.DATASIZE(DATASIZE), .ADDRSIZE(ADDRSIZE)) u_ram (
        .clk  (wclk),
        .rst  (wrst),
        .we   (we),
        .waddr(wptr[PW-2:0]),
        .wdata(wdata),
        .re   (re),
        .raddr(rptr[PW-2:0]),
        .rdata(rdata)
    );
endmodule

// File: tb/tb_sync_fifo_ctrl_mem.sv
// tb_sync_fifo_ctrl_mem: directed and randomized checks against a queue-based FIFO model
module tb_sync_fifo_ctrl_mem;
    logic       wclk = 1'b0;
    logic       wrst = 1'b0;
    logic       winc = 1'b0;
    logic [7:0] wdata = '0;
    logic       rinc = 1'b0;
    logic [7:0] rdata;
    logic       rvalid, wfull, walmost_full, rempty, ralmost_empty, overflow, underflow;
    logic [2:0] count;
    int checks = 0;
    int failures = 0;
    logic [7:0] q[$];
    logic       m_valid = 1'b0;
    logic [7:0] m_rdata = '0;
    logic       m_ovf = 1'b0;
    logic       m_udf = 1'b0;

    sync_fifo_ctrl_mem #(.DATASIZE(8), .ADDRSIZE(2), .AFULL_THRESH(3), .AEMPTY_THRESH(1)) dut (
        .wclk(wclk), .wrst(wrst), .winc(winc), .wdata(wdata), .rinc(rinc),
        .rdata(rdata), .rvalid(rvalid), .wfull(wfull), .walmost_full(walmost_full),
        .rempty(rempty), .ralmost_empty(ralmost_empty), .count(count),
        .overflow(overflow), .underflow(underflow)
    );

    always #5 wclk = ~wclk;

    task automatic cycle(input logic w, input logic [7:0] d, input logic r);
        int n;
        winc = w;
        wdata = d;
        rinc = r;
        n = q.size();
        @(posedge wclk);
        if (wrst) begin
            q.delete();
            m_valid = 1'b0;
            m_rdata = '0;
            m_ovf = 1'b0;
            m_udf = 1'b0;
        end else begin
            m_valid = r && n > 0;
            if (m_valid) m_rdata = q.pop_front();
            if (w && n < 4) q.push_back(d);
            if (w && n == 4) m_ovf = 1'b1;
            if (r && n == 0) m_udf = 1'b1;
        end
        #1;
        winc = 1'b0;
        rinc = 1'b0;
    endtask

    task automatic do_reset();
        wrst = 1'b1;
        cycle(1'b0, 8'h00, 1'b0);
        wrst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        cycle(1'b0, 8'h00, 1'b0);
        checks++;
        if ({rempty, wfull, walmost_full, ralmost_empty, rvalid, overflow, underflow} !== 7'b1001000) begin
            failures++;
            $display("FAIL reset_flags got=%b want=1001000", {rempty, wfull, walmost_full, ralmost_empty, rvalid, overflow, underflow});
        end
        checks++;
        if (count !== 3'd0 || rdata !== 8'h00) begin
            failures++;
            $display("FAIL reset_count_rdata got count=%0d rdata=%h want 0/00", count, rdata);
        end
    endtask

    task automatic test_fill();
        for (int i = 0; i < 4; i++) begin
            cycle(1'b1, 8'(8'hA1 + i), 1'b0);
            checks++;
            if (count !== 3'(i + 1) || walmost_full !== (i >= 2) || wfull !== (i == 3)) begin
                failures++;
                $display("FAIL fill_%0d got count=%0d afull=%b full=%b want count=%0d afull=%b full=%b",
                         i, count, walmost_full, wfull, i + 1, i >= 2, i == 3);
            end
        end
        cycle(1'b1, 8'hA5, 1'b0);
        checks++;
        if (overflow !== 1'b1 || count !== 3'd4 || underflow !== 1'b0) begin
            failures++;
            $display("FAIL fill_overflow got ovf=%b count=%0d udf=%b want 1/4/0", overflow, count, underflow);
        end
    endtask

    task automatic test_drain();
        for (int i = 0; i < 4; i++) begin
            cycle(1'b0, 8'h00, 1'b1);
            checks++;
            if (rvalid !== 1'b1 || rdata !== 8'(8'hA1 + i) || count !== 3'(3 - i) || rempty !== (i == 3)) begin
                failures++;
                $display("FAIL drain_%0d got v=%b d=%h count=%0d empty=%b want v=1 d=%h count=%0d empty=%b",
                         i, rvalid, rdata, count, rempty, 8'(8'hA1 + i), 3 - i, i == 3);
            end
        end
        cycle(1'b0, 8'h00, 1'b1);
        checks++;
        if (underflow !== 1'b1 || rvalid !== 1'b0 || rdata !== 8'hA4) begin
            failures++;
            $display("FAIL drain_underflow got udf=%b v=%b d=%h want 1/0/a4", underflow, rvalid, rdata);
        end
    endtask

    task automatic test_wrap();
        do_reset();
        for (int i = 0; i <= 10; i++) begin
            cycle(i < 10, 8'(8'h10 + i), i > 0);
            checks++;
            if (count > 3'd1 || count !== 3'(q.size())) begin
                failures++;
                $display("FAIL wrap_count_%0d got=%0d want=%0d", i, count, q.size());
            end
            if (i > 0) begin
                checks++;
                if (rvalid !== 1'b1 || rdata !== 8'(8'h10 + i - 1)) begin
                    failures++;
                    $display("FAIL wrap_data_%0d got v=%b d=%h want v=1 d=%h", i, rvalid, rdata, 8'(8'h10 + i - 1));
                end
            end
        end
        checks++;
        if (overflow !== 1'b0 || underflow !== 1'b0 || rempty !== 1'b1) begin
            failures++;
            $display("FAIL wrap_errors got ovf=%b udf=%b empty=%b want 0/0/1", overflow, underflow, rempty);
        end
    endtask

    task automatic test_simultaneous();
        do_reset();
        cycle(1'b1, 8'h31, 1'b0);
        cycle(1'b1, 8'h32, 1'b0);
        cycle(1'b1, 8'h55, 1'b1);
        checks++;
        if (count !== 3'd2 || rvalid !== 1'b1 || rdata !== 8'h31) begin
            failures++;
            $display("FAIL simul_mid got count=%0d v=%b d=%h want 2/1/31", count, rvalid, rdata);
        end
        cycle(1'b1, 8'h33, 1'b0);
        cycle(1'b1, 8'h34, 1'b0);
        cycle(1'b1, 8'h66, 1'b1);
        checks++;
        if (count !== 3'd3 || overflow !== 1'b1 || rdata !== 8'h32 || rvalid !== 1'b1) begin
            failures++;
            $display("FAIL simul_full got count=%0d ovf=%b d=%h v=%b want 3/1/32/1", count, overflow, rdata, rvalid);
        end
        for (int i = 0; i < 3; i++) cycle(1'b0, 8'h00, 1'b1);
        checks++;
        if (rdata !== 8'h34 || rempty !== 1'b1) begin
            failures++;
            $display("FAIL simul_drain got d=%h empty=%b want 34/1 (66 must be dropped)", rdata, rempty);
        end
        cycle(1'b1, 8'h77, 1'b1);
        checks++;
        if (count !== 3'd1 || underflow !== 1'b1 || rvalid !== 1'b0) begin
            failures++;
            $display("FAIL simul_empty got count=%0d udf=%b v=%b want 1/1/0", count, underflow, rvalid);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int i = 0; i < 5; i++) cycle(1'b1, 8'(8'h40 + i), 1'b0);
        cycle(1'b0, 8'h00, 1'b1);
        checks++;
        if (count !== 3'd3 || overflow !== 1'b1) begin
            failures++;
            $display("FAIL midrst_setup got count=%0d ovf=%b want 3/1", count, overflow);
        end
        do_reset();
        checks++;
        if (count !== 3'd0 || rempty !== 1'b1 || overflow !== 1'b0 || rvalid !== 1'b0) begin
            failures++;
            $display("FAIL midrst_clear got count=%0d empty=%b ovf=%b v=%b want 0/1/0/0", count, rempty, overflow, rvalid);
        end
        cycle(1'b1, 8'h77, 1'b0);
        cycle(1'b0, 8'h00, 1'b1);
        checks++;
        if (rvalid !== 1'b1 || rdata !== 8'h77) begin
            failures++;
            $display("FAIL midrst_data got v=%b d=%h want 1/77", rvalid, rdata);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 400; i++) begin
            wrst = ($urandom_range(0, 59) == 0);
            cycle($urandom_range(0, 1) == 1, 8'($urandom), $urandom_range(0, 1) == 1);
            wrst = 1'b0;
            checks++;
            if (count !== 3'(q.size()) || rempty !== (q.size() == 0) || wfull !== (q.size() == 4) ||
                walmost_full !== (q.size() >= 3) || ralmost_empty !== (q.size() <= 1) ||
                rvalid !== m_valid || rdata !== m_rdata || overflow !== m_ovf || underflow !== m_udf) begin
                failures++;
                $display("FAIL random_%0d got c=%0d e=%b f=%b af=%b ae=%b v=%b d=%h o=%b u=%b want c=%0d v=%b d=%h o=%b u=%b",
                         i, count, rempty, wfull, walmost_full, ralmost_empty, rvalid, rdata, overflow, underflow,
                         q.size(), m_valid, m_rdata, m_ovf, m_udf);
            end
        end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_drain();
        test_wrap();
        test_simultaneous();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
